// File: rtl/bpu_ftq_if.sv
// Prediction-in and retire-in channel between bpu/backend and the fetch target queue.
// Signal names keep the ftq-side port names so the slave view reads like plain ports.
interface bpu_ftq_if #(
  parameter int PC       = 64,
  parameter int TAGE_IND = 4
);
  logic                bpu_b4_val_i;
  logic [PC-1:0]       bpu_b4_pc_i;
  logic                bpu_b4_pred_taken_i;
  logic [TAGE_IND-1:0] bpu_b4_tage_index_i;
  logic                ftq_rdy_o;
  logic                ret_val_i;
  logic                ret_taken_i;

  modport master (
    output bpu_b4_val_i,
    output bpu_b4_pc_i,
    output bpu_b4_pred_taken_i,
    output bpu_b4_tage_index_i,
    output ret_val_i,
    output ret_taken_i,
    input  ftq_rdy_o
  );

  modport slave (
    input  bpu_b4_val_i,
    input  bpu_b4_pc_i,
    input  bpu_b4_pred_taken_i,
    input  bpu_b4_tage_index_i,
    input  ret_val_i,
    input  ret_taken_i,
    output ftq_rdy_o
  );
endinterface

// File: rtl/bpu_ftq.sv
// Fetch target queue behind the b4 predictor stage: in-order hold until retire,
// then bpu training update, mispredict flush, committed history and stats.
module bpu_ftq #(
  parameter int PC       = 64,
  parameter int TAGE_IND = 4,
  parameter int DEPTH    = 16,
  parameter int HIST     = 113
) (
  input  logic                clk,
  input  logic                rst,
  bpu_ftq_if.slave            ftq,
  output logic                bpu_update_o,
  output logic [PC-1:0]       bpu_pc_o,
  output logic [TAGE_IND-1:0] bpu_tage_ind_o,
  output logic                bpu_taken_o,
  output logic                bpu_flush_o,
  output logic [HIST-1:0]     ghr_o,
  output logic [31:0]         commit_cnt_o,
  output logic [31:0]         misp_cnt_o,
  output logic                err_o
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {RUN, FLUSH} state_e;

  typedef struct packed {
    logic [PC-1:0]       pc;
    logic                tk;
    logic [TAGE_IND-1:0] ti;
  } ent_t;

  ent_t                mem_q [DEPTH];
  logic [AW:0]         wr_q, wr_d;
  logic [AW:0]         rd_q, rd_d;
  state_e              state_q;
  logic                upd_q;
  logic [PC-1:0]       pc_q;
  logic [TAGE_IND-1:0] ti_q;
  logic                tk_q;
  logic                flush_q;
  logic [HIST-1:0]     ghr_q;
  logic [31:0]         ccnt_q;
  logic [31:0]         mcnt_q;
  logic                err_q;

  logic empty, full, run;
  logic enq, ret, misp, err_d;
  ent_t head, went;

  assign run   = state_q == RUN;
  assign empty = wr_q == rd_q;
  assign full  = (wr_q[AW-1:0] == rd_q[AW-1:0])
              && (wr_q[AW] != rd_q[AW]);
  assign ftq.ftq_rdy_o = !full && run;

  assign head = mem_q[rd_q[AW-1:0]];
  assign went = '{pc: ftq.bpu_b4_pc_i,
                  tk: ftq.bpu_b4_pred_taken_i,
                  ti: ftq.bpu_b4_tage_index_i};

  assign enq   = ftq.bpu_b4_val_i && ftq.ftq_rdy_o;
  assign ret   = ftq.ret_val_i && run && !empty;
  assign misp  = ret && (ftq.ret_taken_i != head.tk);
  assign err_d = run && ((ftq.bpu_b4_val_i && full)
                      || (ftq.ret_val_i && empty));

  // A mispredict discards everything younger, including a same-cycle enqueue.
  always_comb begin
    wr_d = wr_q + (AW+1)'(enq);
    rd_d = rd_q + (AW+1)'(ret);
    if (misp) begin
      wr_d = '0;
      rd_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_q[AW-1:0]] <= went;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      state_q <= RUN;
      upd_q   <= 1'b0;
      pc_q    <= '0;
      ti_q    <= '0;
      tk_q    <= 1'b0;
      flush_q <= 1'b0;
      ghr_q   <= '0;
      ccnt_q  <= '0;
      mcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      upd_q   <= ret;
      flush_q <= misp;
      if (ret) begin
        pc_q   <= head.pc;
        ti_q   <= head.ti;
        tk_q   <= ftq.ret_taken_i;
        ghr_q  <= {ghr_q[HIST-2:0], ftq.ret_taken_i};
        ccnt_q <= ccnt_q + 32'd1;
      end
      if (misp)  mcnt_q <= mcnt_q + 32'd1;
      if (err_d) err_q  <= 1'b1;
      unique case (state_q)
        RUN:     state_q <= misp ? FLUSH : RUN;
        FLUSH:   state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  assign bpu_update_o   = upd_q;
  assign bpu_pc_o       = pc_q;
  assign bpu_tage_ind_o = ti_q;
  assign bpu_taken_o    = tk_q;
  assign bpu_flush_o    = flush_q;
  assign ghr_o          = ghr_q;
  assign commit_cnt_o   = ccnt_q;
  assign misp_cnt_o     = mcnt_q;
  assign err_o          = err_q;
endmodule

// File: tb/tb_bpu_ftq.sv
// Scoreboard bench for bpu_ftq: expected updates are queued at retire
// and checked by a monitor when bpu_update_o fires.
module tb_bpu_ftq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bpu_ftq_if #(.PC(64), .TAGE_IND(4)) bus ();

  logic         upd;
  logic [63:0]  upc;
  logic [3:0]   uti;
  logic         utk;
  logic         ufl;
  logic [112:0] ghr;
  logic [31:0]  ccnt;
  logic [31:0]  mcnt;
  logic         err;

  bpu_ftq dut (
    .clk            (clk),
    .rst            (rst),
    .ftq            (bus),
    .bpu_update_o   (upd),
    .bpu_pc_o       (upc),
    .bpu_tage_ind_o (uti),
    .bpu_taken_o    (utk),
    .bpu_flush_o    (ufl),
    .ghr_o          (ghr),
    .commit_cnt_o   (ccnt),
    .misp_cnt_o     (mcnt),
    .err_o          (err)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [3:0]  ti;
    logic        tk;
    logic        fl;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t mq[$];
  exp_t got, want;

  always @(negedge clk) begin
    if (!rst) begin
      if (upd) begin
        tests++;
        got = '{pc: upc, ti: uti, tk: utk, fl: ufl};
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL update_unexpected: got pc=%h ti=%h tk=%b fl=%b, required none",
                   upc, uti, utk, ufl);
        end else begin
          want = sb.pop_front();
          if (got !== want) begin
            fails++;
            $display("FAIL update: got pc=%h ti=%h tk=%b fl=%b, required pc=%h ti=%h tk=%b fl=%b",
                     got.pc, got.ti, got.tk, got.fl, want.pc, want.ti, want.tk, want.fl);
          end
        end
      end else if (ufl) begin
        tests++;
        fails++;
        $display("FAIL flush_alone: got flush=1 without update, required 0");
      end
    end
  end

  task automatic drive(input logic v, input logic [63:0] pc, input logic pt,
                       input logic [3:0] ti, input logic rv, input logic rt);
    bus.bpu_b4_val_i        = v;
    bus.bpu_b4_pc_i         = pc;
    bus.bpu_b4_pred_taken_i = pt;
    bus.bpu_b4_tage_index_i = ti;
    bus.ret_val_i           = rv;
    bus.ret_taken_i         = rt;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 64'h0, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic enq(input logic [63:0] pc, input logic pt, input logic [3:0] ti);
    mq.push_back('{pc: pc, ti: ti, tk: pt, fl: 1'b0});
    drive(1'b1, pc, pt, ti, 1'b0, 1'b0);
  endtask

  task automatic retire(input logic rt);
    exp_t h;
    h = mq.pop_front();
    sb.push_back('{pc: h.pc, ti: h.ti, tk: rt, fl: (rt != h.tk)});
    drive(1'b0, 64'h0, 1'b0, 4'h0, 1'b1, rt);
  endtask

  task automatic both(input logic [63:0] pc, input logic pt, input logic [3:0] ti);
    exp_t h;
    h = mq.pop_front();
    sb.push_back('{pc: h.pc, ti: h.ti, tk: h.tk, fl: 1'b0});
    mq.push_back('{pc: pc, ti: ti, tk: pt, fl: 1'b0});
    drive(1'b1, pc, pt, ti, 1'b1, h.tk);
  endtask

  task automatic test_reset();
    tests++;
    if ({upd, ufl, utk, err} !== 4'b0 || upc !== 64'h0 || uti !== 4'h0) begin
      fails++;
      $display("FAIL reset_outs: got upd=%b fl=%b tk=%b err=%b pc=%h ti=%h, required all 0",
               upd, ufl, utk, err, upc, uti);
    end
    tests++;
    if (ghr !== 113'h0 || ccnt !== 32'h0 || mcnt !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: got ghr=%h ccnt=%0d mcnt=%0d, required 0", ghr, ccnt, mcnt);
    end
    tests++;
    if (bus.ftq_rdy_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_rdy: got %b, required 1", bus.ftq_rdy_o);
    end
  endtask

  task automatic test_basic();
    enq(64'h100, 1'b1, 4'h1);
    enq(64'h104, 1'b0, 4'h2);
    enq(64'h108, 1'b1, 4'h3);
    retire(1'b1);
    retire(1'b0);
    retire(1'b1);
    idle();
    tests++;
    if (ccnt !== 32'd3 || mcnt !== 32'd0) begin
      fails++;
      $display("FAIL basic_cnt: got commit=%0d misp=%0d, required 3 0", ccnt, mcnt);
    end
    tests++;
    if (ghr[2:0] !== 3'b101) begin
      fails++;
      $display("FAIL basic_ghr: got %b, required 101", ghr[2:0]);
    end
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL basic_err: got %b, required 0", err);
    end
  endtask

  task automatic test_misp();
    logic [31:0] c0, m0;
    c0 = ccnt;
    m0 = mcnt;
    enq(64'h200, 1'b1, 4'h9);
    enq(64'h204, 1'b1, 4'h1);
    enq(64'h208, 1'b0, 4'h2);
    retire(1'b0);
    mq.delete();
    tests++;
    if (mcnt !== m0 + 32'd1 || ccnt !== c0 + 32'd1) begin
      fails++;
      $display("FAIL misp_cnt: got misp=%0d commit=%0d, required %0d %0d",
               mcnt, ccnt, m0 + 32'd1, c0 + 32'd1);
    end
    tests++;
    if (bus.ftq_rdy_o !== 1'b0) begin
      fails++;
      $display("FAIL misp_rdy_flush: got %b, required 0", bus.ftq_rdy_o);
    end
    drive(1'b1, 64'hBAD, 1'b1, 4'hF, 1'b0, 1'b0);
    tests++;
    if (bus.ftq_rdy_o !== 1'b1 || err !== 1'b0) begin
      fails++;
      $display("FAIL misp_after: got rdy=%b err=%b, required 1 0", bus.ftq_rdy_o, err);
    end
    enq(64'h300, 1'b0, 4'h5);
    retire(1'b0);
    idle();
  endtask

  task automatic test_wrap();
    logic [31:0] c0, m0;
    c0 = ccnt;
    m0 = mcnt;
    enq(64'h4000, 1'($urandom_range(0, 1)), 4'h0);
    for (int i = 1; i < 40; i++)
      both(64'h4000 + 64'(i * 4), 1'($urandom_range(0, 1)), 4'(i));
    retire(mq[0].tk);
    idle();
    tests++;
    if (ccnt !== c0 + 32'd40 || mcnt !== m0) begin
      fails++;
      $display("FAIL wrap_cnt: got commit=%0d misp=%0d, required %0d %0d",
               ccnt, mcnt, c0 + 32'd40, m0);
    end
  endtask

  task automatic test_full();
    logic [31:0] c0;
    exp_t h;
    c0 = ccnt;
    for (int i = 0; i < 16; i++)
      enq(64'h1000 + 64'(i * 4), 1'(i), 4'(i));
    tests++;
    if (bus.ftq_rdy_o !== 1'b0) begin
      fails++;
      $display("FAIL full_rdy: got %b, required 0", bus.ftq_rdy_o);
    end
    drive(1'b1, 64'hDEAD, 1'b1, 4'h0, 1'b0, 1'b0);
    tests++;
    if (err !== 1'b1 || bus.ftq_rdy_o !== 1'b0) begin
      fails++;
      $display("FAIL full_overflow: got err=%b rdy=%b, required 1 0", err, bus.ftq_rdy_o);
    end
    h = mq.pop_front();
    sb.push_back('{pc: h.pc, ti: h.ti, tk: h.tk, fl: 1'b0});
    drive(1'b1, 64'hBEEF, 1'b0, 4'h0, 1'b1, h.tk);
    tests++;
    if (bus.ftq_rdy_o !== 1'b1) begin
      fails++;
      $display("FAIL full_retire_rdy: got %b, required 1", bus.ftq_rdy_o);
    end
    for (int i = 0; i < 15; i++) retire(mq[0].tk);
    idle();
    tests++;
    if (ccnt !== c0 + 32'd16) begin
      fails++;
      $display("FAIL full_drain: got commit=%0d, required %0d", ccnt, c0 + 32'd16);
    end
  endtask

  task automatic test_empty();
    logic [31:0] c0, m0;
    c0 = ccnt;
    m0 = mcnt;
    drive(1'b0, 64'h0, 1'b0, 4'h0, 1'b1, 1'b1);
    tests++;
    if (upd !== 1'b0 || err !== 1'b1) begin
      fails++;
      $display("FAIL empty_ret: got upd=%b err=%b, required 0 1", upd, err);
    end
    tests++;
    if (ccnt !== c0 || mcnt !== m0) begin
      fails++;
      $display("FAIL empty_cnt: got commit=%0d misp=%0d, required %0d %0d", ccnt, mcnt, c0, m0);
    end
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 5; i++)
      enq(64'h8000 + 64'(i * 4), 1'b1, 4'(i));
    rst = 1'b1;
    #1;
    mq.delete();
    tests++;
    if ({upd, ufl, err} !== 3'b0 || ccnt !== 32'h0 || mcnt !== 32'h0
        || ghr !== 113'h0 || upc !== 64'h0) begin
      fails++;
      $display("FAIL rst_mid_outs: got upd=%b fl=%b err=%b ccnt=%0d mcnt=%0d pc=%h, required 0",
               upd, ufl, err, ccnt, mcnt, upc);
    end
    tests++;
    if (bus.ftq_rdy_o !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_rdy: got %b, required 1", bus.ftq_rdy_o);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 4'h0, 1'b1, 1'b1);
    tests++;
    if (err !== 1'b1 || upd !== 1'b0 || ccnt !== 32'h0) begin
      fails++;
      $display("FAIL rst_mid_ret: got err=%b upd=%b ccnt=%0d, required 1 0 0", err, upd, ccnt);
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    bus.bpu_b4_val_i        = 1'b0;
    bus.bpu_b4_pc_i         = '0;
    bus.bpu_b4_pred_taken_i = 1'b0;
    bus.bpu_b4_tage_index_i = '0;
    bus.ret_val_i           = 1'b0;
    bus.ret_taken_i         = 1'b0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    idle();
    test_basic();
    test_misp();
    test_wrap();
    test_full();
    test_empty();
    test_rst_mid();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d pending updates, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
